// File: rtl/fetch_ctrl_if.sv
// Bus bundle between the fetch sequencer, instruction memory, execute redirect and decode.
// The master modport is the fetch_ctrl side. The slave modport is the environment side.
interface fetch_ctrl_if;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        imem_req_valid;
   logic [31:0] imem_req_addr;
   logic        imem_req_ready;
   logic        imem_rsp_valid;
   logic [31:0] imem_rsp_data;
   logic        if_valid;
   logic [31:0] if_pc;
   logic [31:0] if_instr;
   logic        if_ready;
   logic [31:0] fetch_count;

   modport master (
      input  redirect_valid, redirect_pc, imem_req_ready, imem_rsp_valid, imem_rsp_data, if_ready,
      output imem_req_valid, imem_req_addr, if_valid, if_pc, if_instr, fetch_count
   );

   modport slave (
      output redirect_valid, redirect_pc, imem_req_ready, imem_rsp_valid, imem_rsp_data, if_ready,
      input  imem_req_valid, imem_req_addr, if_valid, if_pc, if_instr, fetch_count
   );
endinterface

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer. It keeps at most one outstanding imem request.
// It discards wrong-path responses after a redirect.
module fetch_ctrl #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic         clk,
   input  logic         rst,
   fetch_ctrl_if.master bus
);
   typedef enum logic [2:0] {IDLE, REQ, WAIT, HOLD, DROP} state_t;

   state_t      state, state_n;
   logic [31:0] pc, pc_n;
   logic [31:0] if_pc_q, if_pc_n;
   logic [31:0] if_instr_q, if_instr_n;
   logic [31:0] cnt_q, cnt_n;
   logic [31:0] redir_pc;

   assign redir_pc = bus.redirect_pc & ~32'h3;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         pc         <= RESET_PC;
         if_pc_q    <= '0;
         if_instr_q <= '0;
         cnt_q      <= '0;
      end else begin
         state      <= state_n;
         pc         <= pc_n;
         if_pc_q    <= if_pc_n;
         if_instr_q <= if_instr_n;
         cnt_q      <= cnt_n;
      end
   end

   // The redirect gates the handshakes combinationally, so a redirect never lets a stale beat through.
   always_comb begin
      state_n    = state;
      pc_n       = pc;
      if_pc_n    = if_pc_q;
      if_instr_n = if_instr_q;
      cnt_n      = cnt_q;
      unique case (state)
         IDLE: state_n = REQ;
         REQ: begin
            if (bus.redirect_valid) pc_n = redir_pc;
            else if (bus.imem_req_ready) state_n = WAIT;
         end
         WAIT: begin
            if (bus.redirect_valid) begin
               pc_n    = redir_pc;
               state_n = bus.imem_rsp_valid ? REQ : DROP;
            end else if (bus.imem_rsp_valid) begin
               if_instr_n = bus.imem_rsp_data;
               if_pc_n    = pc;
               pc_n       = pc + 32'd4;
               state_n    = HOLD;
            end
         end
         DROP: begin
            if (bus.redirect_valid) pc_n = redir_pc;
            if (bus.imem_rsp_valid) state_n = REQ;
         end
         HOLD: begin
            if (bus.redirect_valid) begin
               pc_n    = redir_pc;
               state_n = REQ;
            end else if (bus.if_ready) begin
               cnt_n   = cnt_q + 32'd1;
               state_n = REQ;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   assign bus.imem_req_valid = (state == REQ) && !bus.redirect_valid;
   assign bus.imem_req_addr  = pc;
   assign bus.if_valid       = (state == HOLD) && !bus.redirect_valid;
   assign bus.if_pc          = if_pc_q;
   assign bus.if_instr       = if_instr_q;
   assign bus.fetch_count    = cnt_q;
endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed cycle-by-cycle vectors for fetch_ctrl. Each row drives one cycle of inputs and gives the expected outputs.
module tb_fetch_ctrl;
   typedef struct {
      logic        rv;
      logic [31:0] rpc;
      logic        rdy;
      logic        rspv;
      logic [31:0] rspd;
      logic        ifr;
      logic        e_reqv;
      logic [31:0] e_addr;
      logic        e_ifv;
      logic [31:0] e_ifpc;
      logic [31:0] e_instr;
      logic [31:0] e_cnt;
   } vec_t;

   localparam logic [31:0] I0 = 32'h1111_1111, I1 = 32'h2222_2222, I2 = 32'h3333_3333;
   localparam logic [31:0] I3 = 32'h4444_4444, I4 = 32'h5555_5555, I5 = 32'h6666_6666;
   localparam logic [31:0] I6 = 32'h7777_7777, I7 = 32'h0A0A_0A0A, DEAD = 32'hDEAD_BEEF;

   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   failures = 0;

   fetch_ctrl_if bus();

   fetch_ctrl dut (.clk(clk), .rst(rst), .bus(bus));

   always #5 clk = ~clk;

   function automatic vec_t mk(logic rv, logic [31:0] rpc, logic rdy, logic rspv, logic [31:0] rspd,
                               logic ifr, logic reqv, logic [31:0] addr, logic ifv,
                               logic [31:0] ifpc, logic [31:0] instr, logic [31:0] cnt);
      vec_t v;
      v.rv = rv; v.rpc = rpc; v.rdy = rdy; v.rspv = rspv; v.rspd = rspd; v.ifr = ifr;
      v.e_reqv = reqv; v.e_addr = addr; v.e_ifv = ifv; v.e_ifpc = ifpc; v.e_instr = instr; v.e_cnt = cnt;
      return v;
   endfunction

   task automatic check_outs(string nm, logic reqv, logic [31:0] addr, logic ifv,
                             logic [31:0] ifpc, logic [31:0] instr, logic [31:0] cnt);
      checks++;
      if (bus.imem_req_valid !== reqv || bus.imem_req_addr !== addr || bus.if_valid !== ifv ||
          bus.if_pc !== ifpc || bus.if_instr !== instr || bus.fetch_count !== cnt) begin
         failures++;
         $display("FAIL %s: got reqv=%0b addr=%h ifv=%0b ifpc=%h instr=%h cnt=%0d, want reqv=%0b addr=%h ifv=%0b ifpc=%h instr=%h cnt=%0d",
                  nm, bus.imem_req_valid, bus.imem_req_addr, bus.if_valid, bus.if_pc, bus.if_instr,
                  bus.fetch_count, reqv, addr, ifv, ifpc, instr, cnt);
      end
   endtask

   // Called at posedge+1. It drives the inputs, checks on the falling edge, and returns at the next posedge+1.
   task automatic run(vec_t v, string nm);
      bus.redirect_valid = v.rv;
      bus.redirect_pc    = v.rpc;
      bus.imem_req_ready = v.rdy;
      bus.imem_rsp_valid = v.rspv;
      bus.imem_rsp_data  = v.rspd;
      bus.if_ready       = v.ifr;
      @(negedge clk);
      check_outs(nm, v.e_reqv, v.e_addr, v.e_ifv, v.e_ifpc, v.e_instr, v.e_cnt);
      @(posedge clk);
      #1;
   endtask

   vec_t tbl[$];

   initial begin
      // Rows below: rv, rpc, rdy, rspv, rspd, ifr | reqv, addr, ifv, ifpc, instr, cnt
      // Free run with single-cycle memory.
      tbl.push_back(mk(0, 0,     1, 0, 0,    1,  0, 32'h0,   0, 0, 0,  0));
      tbl.push_back(mk(0, 0,     1, 0, 0,    1,  1, 32'h0,   0, 0, 0,  0));
      tbl.push_back(mk(0, 0,     0, 1, I0,   1,  0, 32'h0,   0, 0, 0,  0));
      tbl.push_back(mk(0, 0,     0, 0, 0,    1,  0, 32'h4,   1, 0, I0, 0));
      tbl.push_back(mk(0, 0,     1, 0, 0,    1,  1, 32'h4,   0, 0, I0, 1));
      tbl.push_back(mk(0, 0,     0, 1, I1,   1,  0, 32'h4,   0, 0, I0, 1));
      tbl.push_back(mk(0, 0,     0, 0, 0,    1,  0, 32'h8,   1, 4, I1, 1));
      tbl.push_back(mk(0, 0,     1, 0, 0,    1,  1, 32'h8,   0, 4, I1, 2));
      tbl.push_back(mk(0, 0,     0, 1, I2,   1,  0, 32'h8,   0, 4, I1, 2));
      tbl.push_back(mk(0, 0,     0, 0, 0,    1,  0, 32'hC,   1, 8, I2, 2));
      tbl.push_back(mk(0, 0,     1, 0, 0,    1,  1, 32'hC,   0, 8, I2, 3));
      // Redirect in WAIT. The response arrives 3 cycles later and is dropped.
      tbl.push_back(mk(1, 32'h100, 0, 0, 0,  1,  0, 32'hC,   0, 8, I2, 3));
      tbl.push_back(mk(0, 0,     0, 0, 0,    1,  0, 32'h100, 0, 8, I2, 3));
      tbl.push_back(mk(0, 0,     0, 0, 0,    1,  0, 32'h100, 0, 8, I2, 3));
      tbl.push_back(mk(0, 0,     0, 1, DEAD, 1,  0, 32'h100, 0, 8, I2, 3));
      tbl.push_back(mk(0, 0,     1, 0, 0,    1,  1, 32'h100, 0, 8, I2, 3));
      tbl.push_back(mk(0, 0,     0, 1, I3,   1,  0, 32'h100, 0, 8, I2, 3));
      // Redirect in HOLD with if_ready high in the same cycle.
      tbl.push_back(mk(1, 32'h300, 0, 0, 0,  1,  0, 32'h104, 0, 32'h100, I3, 3));
      // Redirect in REQ with ready high. The target has its low bits masked.
      tbl.push_back(mk(1, 32'h203, 1, 0, 0,  1,  0, 32'h300, 0, 32'h100, I3, 3));
      // imem_req_ready held low for 4 cycles.
      for (int i = 0; i < 4; i++)
         tbl.push_back(mk(0, 0,  0, 0, 0,    1,  1, 32'h200, 0, 32'h100, I3, 3));
      tbl.push_back(mk(0, 0,     1, 0, 0,    1,  1, 32'h200, 0, 32'h100, I3, 3));
      tbl.push_back(mk(0, 0,     0, 1, I4,   0,  0, 32'h200, 0, 32'h100, I3, 3));
      // if_ready held low for 5 cycles.
      for (int i = 0; i < 5; i++)
         tbl.push_back(mk(0, 0,  0, 0, 0,    0,  0, 32'h204, 1, 32'h200, I4, 3));
      tbl.push_back(mk(0, 0,     0, 0, 0,    1,  0, 32'h204, 1, 32'h200, I4, 3));
      tbl.push_back(mk(0, 0,     1, 0, 0,    1,  1, 32'h204, 0, 32'h200, I4, 4));
      // Redirect and response arrive in the same WAIT cycle.
      tbl.push_back(mk(1, 32'h400, 0, 1, I5, 1,  0, 32'h204, 0, 32'h200, I4, 4));
      tbl.push_back(mk(0, 0,     1, 0, 0,    1,  1, 32'h400, 0, 32'h200, I4, 4));
      // Chained redirects through DROP. The last one coincides with the response.
      tbl.push_back(mk(1, 32'h500, 0, 0, 0,  1,  0, 32'h400, 0, 32'h200, I4, 4));
      tbl.push_back(mk(1, 32'h600, 0, 0, 0,  1,  0, 32'h500, 0, 32'h200, I4, 4));
      tbl.push_back(mk(1, 32'h700, 0, 1, DEAD, 1, 0, 32'h600, 0, 32'h200, I4, 4));
      tbl.push_back(mk(0, 0,     0, 0, 0,    1,  1, 32'h700, 0, 32'h200, I4, 4));

      bus.redirect_valid = 0; bus.redirect_pc = 0; bus.imem_req_ready = 0;
      bus.imem_rsp_valid = 0; bus.imem_rsp_data = 0; bus.if_ready = 0;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check_outs("reset_state", 0, 32'h0, 0, 0, 0, 0);
      rst = 1'b0;

      foreach (tbl[i]) run(tbl[i], $sformatf("vec%0d", i));

      // PC wraps from 0xFFFF_FFFC to 0 after delivery.
      run(mk(1, 32'hFFFF_FFFE, 1, 0, 0, 1, 0, 32'h700,       0, 32'h200, I4, 4), "wrap_redir");
      run(mk(0, 0,             1, 0, 0, 1, 1, 32'hFFFF_FFFC, 0, 32'h200, I4, 4), "wrap_req");
      run(mk(0, 0,             0, 1, I6, 1, 0, 32'hFFFF_FFFC, 0, 32'h200, I4, 4), "wrap_wait");
      run(mk(0, 0,             0, 0, 0, 1, 0, 32'h0,         1, 32'hFFFF_FFFC, I6, 4), "wrap_hold");
      run(mk(0, 0,             1, 0, 0, 1, 1, 32'h0,         0, 32'hFFFF_FFFC, I6, 5), "wrap_next");

      // The DUT is now in WAIT. Assert reset between clock edges.
      bus.imem_req_ready = 0; bus.if_ready = 0;
      @(negedge clk);
      check_outs("pre_async_rst", 0, 32'h0, 0, 32'hFFFF_FFFC, I6, 5);
      rst = 1'b1;
      #1;
      check_outs("async_rst", 0, 32'h0, 0, 0, 0, 0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      run(mk(0, 0, 1, 0, 0,  1, 0, 32'h0, 0, 0, 0,  0), "rst_idle");
      run(mk(0, 0, 1, 0, 0,  1, 1, 32'h0, 0, 0, 0,  0), "rst_req");
      run(mk(0, 0, 0, 1, I7, 1, 0, 32'h0, 0, 0, 0,  0), "rst_wait");
      run(mk(0, 0, 0, 0, 0,  1, 0, 32'h4, 1, 0, I7, 0), "rst_hold");
      run(mk(0, 0, 0, 0, 0,  1, 1, 32'h4, 0, 0, I7, 1), "rst_next");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
